vram_arbiter: RTL and testbench

//  Shares the single-port VRAM (32-bit words, 15-bit address) between the VGA

---
 rtl/vram_arbiter.sv | 142 ++++++++++++++
 tb/tb_vram_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port VRAM between the display fetch port and a host port.
// Display wins by default; host aging and a post-fetch display holdoff bound host latency.
`default_nettype none

module vram_arbiter #(
    parameter int READ_LAT      = 1,
    parameter int DISP_HOLDOFF  = 2,
    parameter int HOST_MAX_WAIT = 64
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        disp_req,
    input  logic [14:0] disp_addr,
    output logic [31:0] disp_data,
    output logic        disp_ready,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [14:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] LAT_INIT  = 3'(READ_LAT - 1);
    localparam logic [7:0] HOLD_INIT = 8'(DISP_HOLDOFF);
    localparam logic [7:0] MAX_WAIT  = 8'(HOST_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [2:0]  lat;
    logic [7:0]  holdoff;
    logic [7:0]  host_wait;
    logic        serving_host;
    logic        serving_write;

    logic        disp_eligible;
    logic        host_wins;
    logic        can_arb;
    logic        grant_host;
    logic        grant_disp;
    logic        complete;
    logic        host_in_flight;

    // DONE arbitrates like IDLE so the next grant lands on the edge that ends ready/ack.
    always_comb begin
        disp_eligible  = disp_req && (holdoff == 8'd0);
        host_wins      = host_req && (!disp_eligible || (host_wait >= MAX_WAIT));
        can_arb        = (state == IDLE) || (state == DONE);
        grant_host     = can_arb && host_wins;
        grant_disp     = can_arb && !host_wins && disp_eligible;
        complete       = (state == WAIT) && (lat == 3'd0);
        host_in_flight = serving_host && ((state == ACCESS) || (state == WAIT));
        state_next     = state;
        case (state)
            IDLE, DONE: state_next = (grant_host || grant_disp) ? ACCESS : IDLE;
            ACCESS:     state_next = WAIT;
            WAIT:       state_next = (lat == 3'd0) ? DONE : WAIT;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            lat           <= 3'd0;
            holdoff       <= 8'd0;
            host_wait     <= 8'd0;
            serving_host  <= 1'b0;
            serving_write <= 1'b0;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 15'd0;
            mem_wdata     <= 32'd0;
            disp_data     <= 32'd0;
            disp_ready    <= 1'b0;
            host_rdata    <= 32'd0;
            host_ack      <= 1'b0;
        end else begin
            mem_en <= grant_host || grant_disp;
            mem_we <= grant_host && host_we;
            if (grant_host) begin
                mem_addr      <= host_addr;
                mem_wdata     <= host_wdata;
                serving_host  <= 1'b1;
                serving_write <= host_we;
            end else if (grant_disp) begin
                mem_addr      <= disp_addr;
                serving_host  <= 1'b0;
                serving_write <= 1'b0;
            end

            if (state == ACCESS) begin
                lat <= LAT_INIT;
            end else if ((state == WAIT) && (lat != 3'd0)) begin
                lat <= lat - 3'd1;
            end

            disp_ready <= complete && !serving_host;
            host_ack   <= complete && serving_host;
            if (complete && !serving_host) begin
                disp_data <= mem_rdata;
            end
            if (complete && serving_host && !serving_write) begin
                host_rdata <= mem_rdata;
            end

            if (complete && !serving_host) begin
                holdoff <= HOLD_INIT;
            end else if (holdoff != 8'd0) begin
                holdoff <= holdoff - 8'd1;
            end

            // The host's own in-flight access does not count as waiting.
            if (!host_req || grant_host) begin
                host_wait <= 8'd0;
            end else if (!host_in_flight && (host_wait != 8'hFF)) begin
                host_wait <= host_wait + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter with a behavioural VRAM model.
// Instance a uses READ_LAT=1/HOST_MAX_WAIT=4, instance b uses READ_LAT=3.
`default_nettype none

module tb_vram_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset   = 1'b1;
    int          checks  = 0;
    int          errors  = 0;

    logic        disp_req_a = 1'b0, host_req_a = 1'b0, host_we_a = 1'b0;
    logic [14:0] disp_addr_a = '0, host_addr_a = '0;
    logic [31:0] host_wdata_a = '0;
    logic [31:0] disp_data_a, host_rdata_a, mem_wdata_a, mem_rdata_a;
    logic        disp_ready_a, host_ack_a, mem_en_a, mem_we_a;
    logic [14:0] mem_addr_a;

    logic        disp_req_b = 1'b0;
    logic [14:0] disp_addr_b = '0;
    logic [31:0] disp_data_b, host_rdata_b, mem_wdata_b, mem_rdata_b;
    logic        disp_ready_b, host_ack_b, mem_en_b, mem_we_b;
    logic [14:0] mem_addr_b;

    logic [31:0] ram [0:32767];
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [0:2];
    int          en_cnt_a = 0;
    int          ready_cnt_b = 0;

    always #5 vga_clk = ~vga_clk;

    vram_arbiter #(.READ_LAT(1), .DISP_HOLDOFF(2), .HOST_MAX_WAIT(4)) dut_a (
        .vga_clk(vga_clk), .reset(reset),
        .disp_req(disp_req_a), .disp_addr(disp_addr_a),
        .disp_data(disp_data_a), .disp_ready(disp_ready_a),
        .host_req(host_req_a), .host_we(host_we_a), .host_addr(host_addr_a),
        .host_wdata(host_wdata_a), .host_rdata(host_rdata_a), .host_ack(host_ack_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    vram_arbiter #(.READ_LAT(3), .DISP_HOLDOFF(2), .HOST_MAX_WAIT(64)) dut_b (
        .vga_clk(vga_clk), .reset(reset),
        .disp_req(disp_req_b), .disp_addr(disp_addr_b),
        .disp_data(disp_data_b), .disp_ready(disp_ready_b),
        .host_req(1'b0), .host_we(1'b0), .host_addr(15'd0),
        .host_wdata(32'd0), .host_rdata(host_rdata_b), .host_ack(host_ack_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    // VRAM model: address captured at the edge ending mem_en, data appears READ_LAT edges later.
    assign mem_rdata_a = pipe_a;
    assign mem_rdata_b = pipe_b[2];

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 32'hA5A50000 | 32'(i);
    end

    always @(posedge vga_clk) begin
        if (mem_en_a && mem_we_a) ram[mem_addr_a] <= mem_wdata_a;
        if (mem_en_a) pipe_a <= ram[mem_addr_a];
        if (mem_en_b) pipe_b[0] <= ram[mem_addr_b];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    always @(negedge vga_clk) begin
        if (mem_en_a) en_cnt_a <= en_cnt_a + 1;
        if (disp_ready_b) ready_cnt_b <= ready_cnt_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // which: 0 = a.disp_ready, 1 = a.host_ack, 2 = b.disp_ready; n = negedges waited
    task automatic wait_for(input int which, input string tag, output int n);
        logic hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 20) begin
            @(negedge vga_clk);
            n++;
            hit = (which == 0) ? disp_ready_a : (which == 1) ? host_ack_a : disp_ready_b;
        end
        check({tag, "_timeout"}, 32'(hit), 32'd1);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge vga_clk);
    endtask

    int n;
    int base;

    initial begin
        idle(2);
        check("rst_mem_en", 32'(mem_en_a), 32'd0);
        check("rst_ready_ack", {30'd0, disp_ready_a, host_ack_a}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
        check("rst_disp_data", disp_data_a, 32'd0);
        reset = 1'b0;
        idle(2);

        // Display read, READ_LAT=1
        disp_req_a = 1'b1; disp_addr_a = 15'h0123;
        @(negedge vga_clk);
        check("t1_en", {31'd0, mem_en_a}, 32'd1);
        check("t1_addr_we", {16'd0, mem_we_a, mem_addr_a}, 32'h0000_0123);
        disp_req_a = 1'b0;
        @(negedge vga_clk);
        check("t1_en_low_ready", {30'd0, mem_en_a, disp_ready_a}, 32'd0);
        @(negedge vga_clk);
        check("t1_ready", {31'd0, disp_ready_a}, 32'd1);
        check("t1_data", disp_data_a, 32'hA5A50123);
        @(negedge vga_clk);
        check("t1_ready_pulse", {31'd0, disp_ready_a}, 32'd0);
        idle(4);

        // Host write then readback
        host_req_a = 1'b1; host_we_a = 1'b1; host_addr_a = 15'h7FFF; host_wdata_a = 32'hDEADBEEF;
        @(negedge vga_clk);
        check("t2_en_we", {30'd0, mem_en_a, mem_we_a}, 32'd3);
        check("t2_addr", 32'(mem_addr_a), 32'h7FFF);
        check("t2_wdata", mem_wdata_a, 32'hDEADBEEF);
        @(negedge vga_clk);
        check("t2_en_we_low", {30'd0, mem_en_a, mem_we_a}, 32'd0);
        @(negedge vga_clk);
        check("t2_ack", {31'd0, host_ack_a}, 32'd1);
        host_req_a = 1'b0;
        @(negedge vga_clk);
        check("t2_ack_pulse", {31'd0, host_ack_a}, 32'd0);
        host_req_a = 1'b1; host_we_a = 1'b0;
        wait_for(1, "t2_rd", n);
        host_req_a = 1'b0;
        check("t2_rdata", host_rdata_a, 32'hDEADBEEF);
        check("t2_disp_data_kept", disp_data_a, 32'hA5A50123);
        idle(4);

        // Simultaneous requests: display first, host on the next arbitration edge
        disp_req_a = 1'b1; disp_addr_a = 15'h0010;
        host_req_a = 1'b1; host_we_a = 1'b0; host_addr_a = 15'h0020;
        @(negedge vga_clk);
        check("t3_disp_first", 32'(mem_addr_a), 32'h0010);
        idle(2);
        check("t3_disp_ready", {31'd0, disp_ready_a}, 32'd1);
        check("t3_disp_data", disp_data_a, 32'hA5A50010);
        @(negedge vga_clk);
        check("t3_host_grant", {16'd0, mem_en_a, mem_addr_a}, 32'h0000_8020);
        disp_req_a = 1'b0;
        idle(2);
        check("t3_host_ack", {31'd0, host_ack_a}, 32'd1);
        check("t3_host_rdata", host_rdata_a, 32'hA5A50020);
        host_req_a = 1'b0;
        idle(5);

        // Display held high continuously: host must still get in
        disp_req_a = 1'b1; disp_addr_a = 15'h0030;
        host_req_a = 1'b1; host_addr_a = 15'h0040;
        n = 0;
        while (!(mem_en_a && mem_addr_a == 15'h0040) && n < 8) begin
            @(negedge vga_clk);
            n++;
        end
        check("t4_host_granted_by_5", 32'(n <= 5), 32'd1);
        check("t4_host_wait_cleared", 32'(dut_a.host_wait), 32'd0);
        wait_for(1, "t4_ack", n);
        disp_req_a = 1'b0; host_req_a = 1'b0;
        idle(5);

        // disp_req lingers one cycle past disp_ready: single fetch only
        base = en_cnt_a;
        disp_req_a = 1'b1; disp_addr_a = 15'h0050;
        wait_for(0, "t6_ready", n);
        check("t6_data", disp_data_a, 32'hA5A50050);
        @(negedge vga_clk);
        disp_req_a = 1'b0;
        idle(6);
        check("t6_single_fetch", 32'(en_cnt_a - base), 32'd1);

        // READ_LAT=3 instance: reset during WAIT drops the access
        disp_req_b = 1'b1; disp_addr_b = 15'h0060;
        @(negedge vga_clk);
        check("t5_grant", {16'd0, mem_en_b, mem_addr_b}, 32'h0000_8060);
        disp_req_b = 1'b0;
        idle(2);
        reset = 1'b1;
        #1;
        check("t5_rst_addr", 32'(mem_addr_b), 32'd0);
        check("t5_rst_ctrl", {28'd0, mem_en_b, mem_we_b, disp_ready_b, host_ack_b}, 32'd0);
        idle(2);
        reset = 1'b0;
        base = ready_cnt_b;
        idle(8);
        check("t5_no_ready_after_rst", 32'(ready_cnt_b - base), 32'd0);
        disp_req_b = 1'b1; disp_addr_b = 15'h0061;
        wait_for(2, "t5_new", n);
        disp_req_b = 1'b0;
        check("t5_latency", 32'(n), 32'd5);
        check("t5_data", disp_data_b, 32'hA5A50061);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
